// File: rtl/turn_pkg.sv
// Shared definitions for the N-player turn sequencer: state encoding,
// player limit and a popcount helper used for end-of-game detection.
package turn_pkg;

  localparam int MAX_PLAYERS = 8;

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    CLEAR = 4'b0010,
    PLAY  = 4'b0100,
    DONE  = 4'b1000
  } state_t;

  function automatic logic [3:0] popcount(input logic [MAX_PLAYERS-1:0] v);
    logic [3:0] cnt;
    cnt = 4'd0;
    for (int i = 0; i < MAX_PLAYERS; i++) begin
      cnt = cnt + 4'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/turn_controller_rr_next_alive.sv
// Combinational round-robin search: first set bit of i_alive strictly after
// i_cur, wrapping; offset NUM_PLAYERS lands back on i_cur itself.
module rr_next_alive #(
  parameter int NUM_PLAYERS = 2,
  parameter int IDX_W       = $clog2(NUM_PLAYERS)
) (
  input  logic [NUM_PLAYERS-1:0] i_alive,
  input  logic [IDX_W-1:0]       i_cur,
  output logic [IDX_W-1:0]       o_next
);

  logic [IDX_W-1:0] w_idx;

  // Scan farthest offset first so the nearest hit is the last one written.
  always_comb begin
    o_next = i_cur;
    w_idx  = '0;
    for (int k = NUM_PLAYERS; k >= 1; k--) begin
      w_idx = IDX_W'((int'(i_cur) + k) % NUM_PLAYERS);
      if (i_alive[w_idx]) begin
        o_next = w_idx;
      end
    end
  end

endmodule

// File: rtl/turn_controller.sv
// Round-robin N-player turn sequencer with per-player chess-clock budgets,
// surrender/timeout elimination and winner/draw detection. All outputs registered.
module turn_controller
  import turn_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int TIME_W      = 12,
  parameter int TIME_INIT   = 600,
  parameter int IDX_W       = $clog2(NUM_PLAYERS)
) (
  input  logic                   clk,
  input  logic                   nRST,
  input  logic                   start,
  input  logic                   tick_en,
  input  logic [NUM_PLAYERS-1:0] move_done,
  input  logic [NUM_PLAYERS-1:0] surrender,
  output logic [3:0]             state,
  output logic                   clr,
  output logic [NUM_PLAYERS-1:0] player_en,
  output logic [IDX_W-1:0]       cur_player,
  output logic [TIME_W-1:0]      time_left,
  output logic [NUM_PLAYERS-1:0] alive,
  output logic [IDX_W-1:0]       winner,
  output logic                   winner_valid,
  output logic                   draw
);

  state_t                   r_state;
  logic                     r_clr;
  logic [NUM_PLAYERS-1:0]   r_pen;
  logic [IDX_W-1:0]         r_cur;
  logic [TIME_W-1:0]        r_tl;
  logic [NUM_PLAYERS-1:0]   r_alive;
  logic [IDX_W-1:0]         r_winner;
  logic                     r_wv;
  logic                     r_draw;
  logic [TIME_W-1:0]        r_time [NUM_PLAYERS];

  logic [TIME_W-1:0]        w_cur_time;
  logic [TIME_W-1:0]        w_time_nxt;
  logic                     w_timeout;
  logic [NUM_PLAYERS-1:0]   w_cur_oh;
  logic [NUM_PLAYERS-1:0]   w_alive_nxt;
  logic                     w_cur_elim;
  logic                     w_adv;
  logic [3:0]               w_pop;
  logic [IDX_W-1:0]         w_next;
  logic [NUM_PLAYERS-1:0]   w_next_oh;

  assign w_cur_time = r_time[r_cur];
  assign w_timeout  = tick_en && (w_cur_time == TIME_W'(1));
  assign w_time_nxt = (tick_en && (w_cur_time != '0)) ? (w_cur_time - TIME_W'(1)) : w_cur_time;
  assign w_cur_oh   = NUM_PLAYERS'(1) << r_cur;

  // Surrenders from any alive player plus a timeout of the active one.
  assign w_alive_nxt = r_alive & ~surrender & ~(w_timeout ? w_cur_oh : '0);
  assign w_cur_elim  = ~|(w_alive_nxt & w_cur_oh);
  assign w_adv       = w_cur_elim | (|(move_done & w_cur_oh));
  assign w_pop       = popcount(MAX_PLAYERS'(w_alive_nxt));
  assign w_next_oh   = NUM_PLAYERS'(1) << w_next;

  // With a single survivor the search wraps onto it, so w_next doubles as the winner.
  rr_next_alive #(
    .NUM_PLAYERS (NUM_PLAYERS),
    .IDX_W       (IDX_W)
  ) u_rr (
    .i_alive (w_alive_nxt),
    .i_cur   (r_cur),
    .o_next  (w_next)
  );

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_state  <= IDLE;
      r_clr    <= 1'b0;
      r_pen    <= '0;
      r_cur    <= '0;
      r_tl     <= '0;
      r_alive  <= '0;
      r_winner <= '0;
      r_wv     <= 1'b0;
      r_draw   <= 1'b0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        r_time[i] <= '0;
      end
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_state  <= CLEAR;
            r_clr    <= 1'b1;
            r_cur    <= '0;
            r_tl     <= TIME_W'(TIME_INIT);
            r_alive  <= '1;
            r_winner <= '0;
            r_wv     <= 1'b0;
            r_draw   <= 1'b0;
            for (int i = 0; i < NUM_PLAYERS; i++) begin
              r_time[i] <= TIME_W'(TIME_INIT);
            end
          end
        end
        CLEAR: begin
          r_state <= PLAY;
          r_clr   <= 1'b0;
          r_pen   <= NUM_PLAYERS'(1);
        end
        PLAY: begin
          r_time[r_cur] <= w_time_nxt;
          r_alive       <= w_alive_nxt;
          if (w_pop <= 4'd1) begin
            r_state <= DONE;
            r_pen   <= '0;
            r_tl    <= w_time_nxt;
            if (w_pop == 4'd1) begin
              r_winner <= w_next;
              r_wv     <= 1'b1;
            end else begin
              r_draw <= 1'b1;
            end
          end else if (w_adv) begin
            r_cur <= w_next;
            r_pen <= w_next_oh;
            r_tl  <= r_time[w_next];
          end else begin
            r_tl <= w_time_nxt;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign state        = r_state;
  assign clr          = r_clr;
  assign player_en    = r_pen;
  assign cur_player   = r_cur;
  assign time_left    = r_tl;
  assign alive        = r_alive;
  assign winner       = r_winner;
  assign winner_valid = r_wv;
  assign draw         = r_draw;

endmodule

// File: tb/tb_turn_controller.sv
// Bench for turn_controller: a 4-player (budget 3) and a 2-player (budget 5)
// instance driven from a vector table through an expected-value queue.
module tb_turn_controller;

  typedef struct packed {
    logic [3:0]  st;
    logic        clr;
    logic [7:0]  pen;
    logic [2:0]  cur;
    logic [11:0] tl;
    logic [7:0]  alive;
    logic [2:0]  win;
    logic        wv;
    logic        draw;
  } obs_t;

  typedef struct {
    int         d;
    logic       st;
    logic       tk;
    logic [7:0] md;
    logic [7:0] su;
    obs_t       exp;
    string      name;
  } vec_t;

  logic clk = 1'b0;
  logic nRST = 1'b0;
  always #5 clk = ~clk;

  logic a_start = 0, a_tick = 0;
  logic [3:0] a_md = '0, a_su = '0;
  logic [3:0] a_state; logic a_clr; logic [3:0] a_pen; logic [1:0] a_cur;
  logic [11:0] a_tl; logic [3:0] a_alive; logic [1:0] a_win; logic a_wv, a_draw;

  logic b_start = 0, b_tick = 0;
  logic [1:0] b_md = '0, b_su = '0;
  logic [3:0] b_state; logic b_clr; logic [1:0] b_pen; logic [0:0] b_cur;
  logic [11:0] b_tl; logic [1:0] b_alive; logic [0:0] b_win; logic b_wv, b_draw;

  turn_controller #(.NUM_PLAYERS(4), .TIME_W(12), .TIME_INIT(3)) u_a (
    .clk(clk), .nRST(nRST), .start(a_start), .tick_en(a_tick),
    .move_done(a_md), .surrender(a_su), .state(a_state), .clr(a_clr),
    .player_en(a_pen), .cur_player(a_cur), .time_left(a_tl), .alive(a_alive),
    .winner(a_win), .winner_valid(a_wv), .draw(a_draw)
  );

  turn_controller #(.NUM_PLAYERS(2), .TIME_W(12), .TIME_INIT(5)) u_b (
    .clk(clk), .nRST(nRST), .start(b_start), .tick_en(b_tick),
    .move_done(b_md), .surrender(b_su), .state(b_state), .clr(b_clr),
    .player_en(b_pen), .cur_player(b_cur), .time_left(b_tl), .alive(b_alive),
    .winner(b_win), .winner_valid(b_wv), .draw(b_draw)
  );

  int checks = 0;
  int failures = 0;
  vec_t vecs[$];
  obs_t exp_q[$];
  string name_q[$];

  function automatic obs_t o(input logic [3:0] s, input logic c, input logic [7:0] p,
                             input logic [2:0] cu, input logic [11:0] t, input logic [7:0] al,
                             input logic [2:0] w, input logic wv, input logic dr);
    obs_t r;
    r.st = s; r.clr = c; r.pen = p; r.cur = cu; r.tl = t;
    r.alive = al; r.win = w; r.wv = wv; r.draw = dr;
    return r;
  endfunction

  function automatic vec_t mk(input int d, input logic st, input logic tk, input logic [7:0] md,
                              input logic [7:0] su, input obs_t e, input string n);
    vec_t v;
    v.d = d; v.st = st; v.tk = tk; v.md = md; v.su = su; v.exp = e; v.name = n;
    return v;
  endfunction

  function automatic obs_t actual(input int d);
    if (d == 0)
      return o(a_state, a_clr, {4'b0, a_pen}, {1'b0, a_cur}, a_tl, {4'b0, a_alive},
               {1'b0, a_win}, a_wv, a_draw);
    return o(b_state, b_clr, {6'b0, b_pen}, {2'b0, b_cur}, b_tl, {6'b0, b_alive},
             {2'b0, b_win}, b_wv, b_draw);
  endfunction

  task automatic check(input int d, input string n, input obs_t e);
    obs_t a;
    a = actual(d);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s dut=%0d got=%h exp=%h", n, d, a, e);
    end
  endtask

  task automatic drive(input int d, input logic st, input logic tk,
                       input logic [7:0] md, input logic [7:0] su);
    a_start = 0; a_tick = 0; a_md = '0; a_su = '0;
    b_start = 0; b_tick = 0; b_md = '0; b_su = '0;
    if (d == 0) begin
      a_start = st; a_tick = tk; a_md = md[3:0]; a_su = su[3:0];
    end else if (d == 1) begin
      b_start = st; b_tick = tk; b_md = md[1:0]; b_su = su[1:0];
    end
  endtask

  initial begin
    obs_t rst_o;
    rst_o = o(4'h1, 0, 8'h0, 0, 12'd0, 8'h0, 0, 0, 0);

    // 4 players, budget 3: rotation, ignored moves, surrender skip, double surrender win
    vecs.push_back(mk(0, 1, 0, 8'h0, 8'h0, o(4'h2, 1, 8'h0, 0, 12'd3, 8'hF, 0, 0, 0), "a_clear"));
    vecs.push_back(mk(0, 0, 0, 8'h0, 8'h0, o(4'h4, 0, 8'h1, 0, 12'd3, 8'hF, 0, 0, 0), "a_play"));
    vecs.push_back(mk(0, 0, 0, 8'h1, 8'h0, o(4'h4, 0, 8'h2, 1, 12'd3, 8'hF, 0, 0, 0), "a_rot1"));
    vecs.push_back(mk(0, 0, 0, 8'h2, 8'h0, o(4'h4, 0, 8'h4, 2, 12'd3, 8'hF, 0, 0, 0), "a_rot2"));
    vecs.push_back(mk(0, 0, 0, 8'h4, 8'h0, o(4'h4, 0, 8'h8, 3, 12'd3, 8'hF, 0, 0, 0), "a_rot3"));
    vecs.push_back(mk(0, 0, 0, 8'h8, 8'h0, o(4'h4, 0, 8'h1, 0, 12'd3, 8'hF, 0, 0, 0), "a_wrap"));
    vecs.push_back(mk(0, 0, 0, 8'h4, 8'h0, o(4'h4, 0, 8'h1, 0, 12'd3, 8'hF, 0, 0, 0), "a_md_notcur"));
    vecs.push_back(mk(0, 0, 1, 8'h0, 8'h0, o(4'h4, 0, 8'h1, 0, 12'd2, 8'hF, 0, 0, 0), "a_tick0"));
    vecs.push_back(mk(0, 0, 0, 8'h0, 8'h2, o(4'h4, 0, 8'h1, 0, 12'd2, 8'hD, 0, 0, 0), "a_surr1"));
    vecs.push_back(mk(0, 0, 0, 8'h1, 8'h0, o(4'h4, 0, 8'h4, 2, 12'd3, 8'hD, 0, 0, 0), "a_skip1"));
    vecs.push_back(mk(0, 0, 0, 8'h2, 8'h0, o(4'h4, 0, 8'h4, 2, 12'd3, 8'hD, 0, 0, 0), "a_md_dead"));
    vecs.push_back(mk(0, 0, 1, 8'h0, 8'h0, o(4'h4, 0, 8'h4, 2, 12'd2, 8'hD, 0, 0, 0), "a_tick2a"));
    vecs.push_back(mk(0, 0, 1, 8'h0, 8'h0, o(4'h4, 0, 8'h4, 2, 12'd1, 8'hD, 0, 0, 0), "a_tick2b"));
    vecs.push_back(mk(0, 0, 0, 8'h0, 8'hC, o(4'h8, 0, 8'h0, 2, 12'd1, 8'h1, 0, 1, 0), "a_win0"));
    vecs.push_back(mk(0, 0, 0, 8'h0, 8'h0, o(4'h8, 0, 8'h0, 2, 12'd1, 8'h1, 0, 1, 0), "a_done_hold"));
    // restart from DONE, then timeout of player 0 with a simultaneous move_done
    vecs.push_back(mk(0, 1, 0, 8'h0, 8'h0, o(4'h2, 1, 8'h0, 0, 12'd3, 8'hF, 0, 0, 0), "a_reclear"));
    vecs.push_back(mk(0, 0, 0, 8'h0, 8'h0, o(4'h4, 0, 8'h1, 0, 12'd3, 8'hF, 0, 0, 0), "a_replay"));
    vecs.push_back(mk(0, 0, 1, 8'h0, 8'h0, o(4'h4, 0, 8'h1, 0, 12'd2, 8'hF, 0, 0, 0), "a_t3"));
    vecs.push_back(mk(0, 0, 1, 8'h0, 8'h0, o(4'h4, 0, 8'h1, 0, 12'd1, 8'hF, 0, 0, 0), "a_t2"));
    vecs.push_back(mk(0, 0, 1, 8'h1, 8'h0, o(4'h4, 0, 8'h2, 1, 12'd3, 8'hE, 0, 0, 0), "a_timeout"));
    vecs.push_back(mk(0, 1, 0, 8'h0, 8'h0, o(4'h4, 0, 8'h2, 1, 12'd3, 8'hE, 0, 0, 0), "a_start_ign"));
    vecs.push_back(mk(0, 0, 1, 8'h0, 8'h1, o(4'h4, 0, 8'h2, 1, 12'd2, 8'hE, 0, 0, 0), "a_surr_dead"));
    vecs.push_back(mk(0, 0, 0, 8'h0, 8'h2, o(4'h4, 0, 8'h4, 2, 12'd3, 8'hC, 0, 0, 0), "a_surr_cur"));
    vecs.push_back(mk(0, 0, 0, 8'h4, 8'h0, o(4'h4, 0, 8'h8, 3, 12'd3, 8'hC, 0, 0, 0), "a_rot_c3"));
    vecs.push_back(mk(0, 0, 0, 8'h8, 8'h0, o(4'h4, 0, 8'h4, 2, 12'd3, 8'hC, 0, 0, 0), "a_wrap_skip"));
    // 2 players, budget 5: handoff, draw, restart with start held through CLEAR
    vecs.push_back(mk(1, 1, 0, 8'h0, 8'h0, o(4'h2, 1, 8'h0, 0, 12'd5, 8'h3, 0, 0, 0), "b_clear"));
    vecs.push_back(mk(1, 0, 0, 8'h0, 8'h0, o(4'h4, 0, 8'h1, 0, 12'd5, 8'h3, 0, 0, 0), "b_play"));
    vecs.push_back(mk(1, 0, 0, 8'h1, 8'h0, o(4'h4, 0, 8'h2, 1, 12'd5, 8'h3, 0, 0, 0), "b_hand1"));
    vecs.push_back(mk(1, 0, 0, 8'h2, 8'h0, o(4'h4, 0, 8'h1, 0, 12'd5, 8'h3, 0, 0, 0), "b_hand0"));
    vecs.push_back(mk(1, 0, 0, 8'h2, 8'h0, o(4'h4, 0, 8'h1, 0, 12'd5, 8'h3, 0, 0, 0), "b_md_notcur"));
    vecs.push_back(mk(1, 0, 0, 8'h0, 8'h3, o(4'h8, 0, 8'h0, 0, 12'd5, 8'h0, 0, 0, 1), "b_draw"));
    vecs.push_back(mk(1, 0, 0, 8'h0, 8'h0, o(4'h8, 0, 8'h0, 0, 12'd5, 8'h0, 0, 0, 1), "b_draw_hold"));
    vecs.push_back(mk(1, 1, 0, 8'h0, 8'h0, o(4'h2, 1, 8'h0, 0, 12'd5, 8'h3, 0, 0, 0), "b_reclear"));
    vecs.push_back(mk(1, 1, 0, 8'h0, 8'h0, o(4'h4, 0, 8'h1, 0, 12'd5, 8'h3, 0, 0, 0), "b_start_in_clr"));
    vecs.push_back(mk(1, 0, 1, 8'h0, 8'h0, o(4'h4, 0, 8'h1, 0, 12'd4, 8'h3, 0, 0, 0), "b_tick1"));
    vecs.push_back(mk(1, 0, 1, 8'h0, 8'h0, o(4'h4, 0, 8'h1, 0, 12'd3, 8'h3, 0, 0, 0), "b_tick2"));

    repeat (2) @(posedge clk);
    #1;
    check(0, "a_in_reset", rst_o);
    check(1, "b_in_reset", rst_o);
    @(negedge clk);
    nRST = 1'b1;
    @(posedge clk);
    #1;
    check(0, "a_after_release", rst_o);
    check(1, "b_after_release", rst_o);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].d, vecs[i].st, vecs[i].tk, vecs[i].md, vecs[i].su);
      exp_q.push_back(vecs[i].exp);
      name_q.push_back(vecs[i].name);
      @(posedge clk);
      #1;
      check(vecs[i].d, name_q.pop_front(), exp_q.pop_front());
    end
    drive(2, 0, 0, 8'h0, 8'h0);

    // asynchronous reset mid-game, between clock edges
    @(posedge clk);
    #2;
    nRST = 1'b0;
    #1;
    check(0, "a_async_rst", rst_o);
    check(1, "b_async_rst", rst_o);
    @(negedge clk);
    b_start = 1'b1;
    nRST = 1'b1;
    @(posedge clk);
    #1;
    check(1, "b_start_after_rst", o(4'h2, 1, 8'h0, 0, 12'd5, 8'h3, 0, 0, 0));
    check(0, "a_idle_after_rst", rst_o);
    b_start = 1'b0;

    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain left=%0d required=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
